// File: rtl/multi_tick_generator.sv
// multi_tick_generator
// Several independent, runtime-programmable tick sources sharing one clock.
// Each channel counts to its own divisor and emits a registered one-cycle
// tick, either periodically or once (one-shot). Channels have a level enable,
// and a global sync pulse restarts every channel in phase.
module multi_tick_generator #(
  parameter int unsigned INPUT_FREQ = 100_000_000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 27,
  parameter int unsigned DEFAULT_HZ = 1000,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy,
  output logic              cfg_err
);

  // Divisor every channel starts with after reset. Guard the division so a
  // zero rate reaches the elaboration check instead of a divide-by-zero.
  localparam longint unsigned RESET_DIV_L =
      (DEFAULT_HZ == 0) ? 64'd0 : (longint'(INPUT_FREQ) / longint'(DEFAULT_HZ));
  localparam logic [CNT_W-1:0] RESET_DIV  = RESET_DIV_L[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W:0]    NUM_CH_L   = NUM_CH[CH_W:0];

  if (NUM_CH < 1 || NUM_CH > 16 || DEFAULT_HZ == 0 || RESET_DIV_L == 0 ||
      RESET_DIV_L >= (64'd1 << CNT_W)) begin : g_bad_params
    $error("multi_tick_generator: illegal NUM_CH or reset divisor");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A write is honoured only for an existing channel and a nonzero divisor.
  logic cfg_ok;
  assign cfg_ok = ({1'b0, cfg_ch} < NUM_CH_L) && (cfg_div != '0);

  // Rejected writes raise a one-cycle error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(gi);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic             mode_reg, mode_next;
    logic             tick_reg, tick_next;
    logic             busy_reg, busy_next;
    logic             wr_hit;
    logic             term;

    assign wr_hit = cfg_we && cfg_ok && (cfg_ch == IDX);
    // Equality compare is enough: every divisor change also clears cnt.
    assign term   = (cnt_reg == (div_reg - ONE));

    // Channel state register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        div_reg   <= RESET_DIV;
        mode_reg  <= 1'b0;
        tick_reg  <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        div_reg   <= div_next;
        mode_reg  <= mode_next;
        tick_reg  <= tick_next;
        busy_reg  <= busy_next;
      end
    end

    // Next-state logic: disable beats a write, a write beats sync, sync
    // beats terminal count. IDLE with enable counts like RUN from cnt=0 so
    // the first tick lands div edges after enable is first seen.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      div_next   = div_reg;
      mode_next  = mode_reg;
      tick_next  = 1'b0;
      if (wr_hit) begin
        div_next  = cfg_div;
        mode_next = cfg_oneshot;
      end
      if (!ch_en[gi]) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else if (wr_hit || sync) begin
        state_next = RUN;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          IDLE, RUN: begin
            if (term) begin
              cnt_next   = '0;
              tick_next  = 1'b1;
              state_next = mode_reg ? DONE : RUN;
            end else begin
              cnt_next   = cnt_reg + ONE;
              state_next = RUN;
            end
          end
          DONE:    cnt_next = '0;
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end
      busy_next = (state_next == RUN);
    end

    assign tick[gi] = tick_reg;
    assign busy[gi] = busy_reg;
  end

endmodule

// File: doc/multi_tick_generator.md
# multi_tick_generator

Multi-channel, runtime-programmable tick source replacing per-instance fixed-rate tick generators. Each of NUM_CH channels produces a registered one-cycle `tick` pulse at a divisor loaded over a simple write port, in periodic or one-shot mode, with per-channel enable and a global counter resync. It sits beside the system clock and feeds scan, debounce, animation and timeout logic that need several independent, retunable rates.

## Interface
- `INPUT_FREQ`, 100_000_000: clk frequency in Hz; used only for the reset divisor.
- `NUM_CH`, 4: channel count, 1..16.
- `CNT_W`, 27: divisor and counter width in bits.
- `DEFAULT_HZ`, 1000: reset-time rate of every channel. Reset divisor is INPUT_FREQ/DEFAULT_HZ. Elaboration fails if this is 0 or does not fit in CNT_W.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  one-cycle configuration write strobe.
- `cfg_ch`  in  max(1,$clog2(NUM_CH))  target channel index.
- `cfg_div`  in  CNT_W  period in clk cycles, ≥1.
- `cfg_oneshot`  in  1  mode: 1 = one-shot, 0 = periodic.
- `ch_en`  in  NUM_CH  per-channel level enable.
- `sync`  in  1  one-cycle pulse that restarts all channels.
- `tick`  out  NUM_CH  registered one-cycle pulses.
- `busy`  out  NUM_CH  channel counting: enabled and not in one-shot DONE.
- `cfg_err`  out  1  one-cycle registered pulse for a rejected write.

## Operation
- Per-channel state: `div[i]` (CNT_W), `mode[i]`, counter `cnt[i]` (CNT_W), FSM {IDLE, RUN, DONE}.
- Reset (async, reset_n=0): `div` = reset divisor, mode periodic, `cnt`=0, FSM IDLE, `tick`=0, `busy`=0, `cfg_err`=0.
- IDLE → RUN on the edge where `ch_en[i]`=1. Any state → IDLE, `cnt`←0, on the edge where `ch_en[i]`=0.
- RUN, `cnt`≠div−1: `cnt`←`cnt`+1, `tick`←0.
- RUN, `cnt`=div−1: `cnt`←0, `tick`←1.
  - Periodic: stay in RUN.
  - One-shot: go to DONE.
- DONE: `cnt` holds 0 and `tick` stays 0 until `ch_en[i]` falls, `sync`, or a config write to the channel.
- `busy[i]` is registered and equals (next state == RUN).
- Config write (`cfg_we`=1):
  - Accepted when `cfg_ch`<NUM_CH and `cfg_div`≠0.
  - On accept: `div`/`mode` load, `cnt`←0, `tick`←0 this edge. FSM goes to RUN if `ch_en` is high, else IDLE. A DONE channel is re-armed.
  - On reject: no state change; `cfg_err`=1 for one cycle.
- `sync`: every channel gets `cnt`←0 and `tick`←0. Enabled channels, including DONE ones, go to RUN. Disabled channels stay IDLE.
- Priority per channel, highest first: reset_n, `ch_en`=0, config write to this channel, `sync`, terminal count.
- `cfg_we` and `sync` in the same cycle: both take effect; the net result is the same for the written channel.
- `div`=1, periodic: `tick` stays high every cycle while enabled.
- Counter compare is equality only. A `div` change always clears `cnt`, so `cnt`>div−1 cannot occur.

## Timing
- `ch_en` first sampled high at edge E0 → first `tick` visible after edge E(div−1), i.e. div edges later. Following ticks come every div cycles.
- Config write at edge W, channel enabled → first tick after edge W+div.
- `sync` at edge S → next tick on every enabled channel after edge S+div, with all channels phase-aligned.
- `cfg_err` is high for exactly the cycle after the rejected write edge.
- All outputs come directly from flops; there are no combinational input-to-output paths.
- reset_n deassertion mid-count: the count restarts from reset values, with no spurious tick.

## Test plan
- Reset, all `ch_en`=1, INPUT_FREQ=1000, DEFAULT_HZ=100 (div 10) → each `tick` first high 10 cycles after enable, then every 10 cycles, 1 cycle wide; `busy`=1.
- Write ch1 div=3 periodic and ch2 div=5 one-shot, both enabled → ch1 ticks at +3, +6, +9…; ch2 ticks once at +5, then `busy[2]`=0 and no further ticks. Toggling `ch_en[2]` low then high → one more tick 5 cycles later.
- Write with cfg_div=0, and with cfg_ch=NUM_CH (NUM_CH=3) → `cfg_err` pulses 1 cycle; `div`/`cnt` unchanged, tick cadence undisturbed.
- `sync` at the cycle where ch0 `cnt`=div−1 → no tick on that edge; all channels tick together div cycles later.
- Write to ch0 on its terminal-count edge, same cycle as `sync` → no tick; next tick after the new div cycles.
- div=1 periodic → `tick` continuously high while enabled. Assert reset_n low mid-run → `tick`, `busy`, `cfg_err` are 0 immediately, asynchronously; `div` returns to the reset divisor.
